// File: rtl/snoop_collector.sv
// Snoop collector: accepts one LLC bus operation at a time, gathers the snoop
// responses of the peer caches, merges them (HITM > HIT > NOHIT) and presents
// the merged result with a valid/ready handshake. WRITE needs no snoop data.
module snoop_collector #(
  parameter int NUM_SNOOPERS = 3,
  parameter int ADDRESS_SIZE = 32,
  parameter int TIMEOUT      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDRESS_SIZE-1:0]   req_addr,
  input  logic [1:0]                req_op,
  input  logic [NUM_SNOOPERS-1:0]   snp_valid,
  input  logic [2*NUM_SNOOPERS-1:0] snp_result,
  output logic                      done_valid,
  input  logic                      done_ready,
  output logic [ADDRESS_SIZE-1:0]   done_addr,
  output logic [1:0]                done_result,
  output logic                      done_timeout
);

  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] RES_NOHIT  = 2'b00;
  localparam logic [1:0] RES_HIT    = 2'b01;
  localparam logic [1:0] RES_HITM   = 2'b10;
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    RESPOND
  } state_t;

  state_t                    state;
  logic [ADDRESS_SIZE-1:0]   addr;
  logic [NUM_SNOOPERS-1:0]   mask;
  logic [NUM_SNOOPERS-1:0]   next_mask;
  logic [1:0]                merged;
  logic [1:0]                next_merged;
  logic [7:0]                timer;

  // Priority merge; the reserved code falls through to NOHIT.
  function automatic logic [1:0] merge2(input logic [1:0] a, input logic [1:0] b);
    if (a == RES_HITM || b == RES_HITM) begin
      return RES_HITM;
    end else if (a == RES_HIT || b == RES_HIT) begin
      return RES_HIT;
    end else begin
      return RES_NOHIT;
    end
  endfunction

  // Fold this cycle's first-time arrivals into the received mask and merged result.
  always_comb begin
    next_mask   = mask;
    next_merged = merged;
    for (int unsigned i = 0; i < NUM_SNOOPERS; i++) begin
      if (snp_valid[i] && !mask[i]) begin
        next_mask[i] = 1'b1;
        next_merged  = merge2(next_merged, snp_result[2*i +: 2]);
      end
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      done_valid   <= 1'b0;
      done_addr    <= '0;
      done_result  <= RES_NOHIT;
      done_timeout <= 1'b0;
      addr         <= '0;
      mask         <= '0;
      merged       <= RES_NOHIT;
      timer        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr      <= req_addr;
            req_ready <= 1'b0;
            if (req_op == OP_WRITE) begin
              state        <= RESPOND;
              done_valid   <= 1'b1;
              done_addr    <= req_addr;
              done_result  <= RES_NOHIT;
              done_timeout <= 1'b0;
            end else begin
              state  <= COLLECT;
              mask   <= '0;
              merged <= RES_NOHIT;
              timer  <= '0;
            end
          end
        end
        COLLECT: begin
          mask   <= next_mask;
          merged <= next_merged;
          // Completion is tested first so it wins over a simultaneous timeout.
          if (&next_mask) begin
            state        <= RESPOND;
            done_valid   <= 1'b1;
            done_addr    <= addr;
            done_result  <= next_merged;
            done_timeout <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            state        <= RESPOND;
            done_valid   <= 1'b1;
            done_addr    <= addr;
            done_result  <= next_merged;
            done_timeout <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESPOND: begin
          if (done_ready) begin
            state      <= IDLE;
            done_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          done_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_collector.sv
// Directed testbench for snoop_collector (3 snoopers, 32-bit address, TIMEOUT=16).
module tb_snoop_collector;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_op;
  logic [2:0]  snp_valid;
  logic [5:0]  snp_result;
  logic        done_valid;
  logic        done_ready;
  logic [31:0] done_addr;
  logic [1:0]  done_result;
  logic        done_timeout;

  int total = 0;
  int bad   = 0;

  snoop_collector #(
    .NUM_SNOOPERS(3),
    .ADDRESS_SIZE(32),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_op(req_op),
    .snp_valid(snp_valid),
    .snp_result(snp_result),
    .done_valid(done_valid),
    .done_ready(done_ready),
    .done_addr(done_addr),
    .done_result(done_result),
    .done_timeout(done_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] op);
    req_valid = 1'b1;
    req_addr  = a;
    req_op    = op;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic snoop(input logic [2:0] v, input logic [5:0] r);
    snp_valid  = v;
    snp_result = r;
    tick();
    snp_valid  = 3'b000;
    snp_result = 6'b000000;
  endtask

  task automatic handshake();
    done_ready = 1'b1;
    tick();
    done_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_op = 2'b00;
    snp_valid = '0; snp_result = '0; done_ready = 1'b0;
    tick();
    // request during reset must not be taken
    req_valid = 1'b1; req_addr = 32'h0000_0BAD; req_op = 2'b00;
    tick();
    req_valid = 1'b0;
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_result", 32'(done_result), 32'd0);
    chk("rst_done_timeout", 32'(done_timeout), 32'd0);
    chk("rst_done_addr", done_addr, 32'd0);
    tick();
    chk("rst_still_idle", 32'(req_ready), 32'd1);

    // READ, all snoopers in one cycle: NOHIT, HIT, NOHIT
    issue(32'h0000_1A40, 2'b00);
    chk("rd_req_ready_busy", 32'(req_ready), 32'd0);
    chk("rd_no_early_done", 32'(done_valid), 32'd0);
    snoop(3'b111, 6'b00_01_00);
    chk("rd_done_valid", 32'(done_valid), 32'd1);
    chk("rd_done_result", 32'(done_result), 32'd1);
    chk("rd_done_timeout", 32'(done_timeout), 32'd0);
    chk("rd_done_addr", done_addr, 32'h0000_1A40);
    handshake();
    chk("rd_back_idle", 32'(req_ready), 32'd1);
    chk("rd_done_dropped", 32'(done_valid), 32'd0);
    chk("rd_addr_hold", done_addr, 32'h0000_1A40);
    chk("rd_result_hold", 32'(done_result), 32'd1);

    // RWIM: snooper 2 HITM cycle 1, snoopers 0,1 HIT cycle 3, snooper 2 repeats in cycle 4
    issue(32'h0000_2000, 2'b11);
    snoop(3'b100, 6'b10_00_00);
    tick();
    chk("rwim_wait", 32'(done_valid), 32'd0);
    snoop(3'b011, 6'b00_01_01);
    chk("rwim_done_valid", 32'(done_valid), 32'd1);
    chk("rwim_done_result", 32'(done_result), 32'd2);
    chk("rwim_done_timeout", 32'(done_timeout), 32'd0);
    // stall the consumer 5 cycles with noise on every input
    snp_valid = 3'b100; snp_result = 6'b00_00_00;
    req_valid = 1'b1; req_addr = 32'h0000_FFFF; req_op = 2'b00;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_valid", 32'(done_valid), 32'd1);
      chk("stall_result", 32'(done_result), 32'd2);
      chk("stall_addr", done_addr, 32'h0000_2000);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    snp_valid = 3'b000; req_valid = 1'b0;
    handshake();
    chk("stall_release_idle", 32'(req_ready), 32'd1);
    chk("stall_release_valid", 32'(done_valid), 32'd0);

    // First response wins; reserved code counts as NOHIT
    issue(32'h0000_3000, 2'b00);
    snoop(3'b001, 6'b00_00_01);
    snoop(3'b001, 6'b00_00_10);
    chk("repeat_wait", 32'(done_valid), 32'd0);
    snoop(3'b110, 6'b11_00_00);
    chk("repeat_done_valid", 32'(done_valid), 32'd1);
    chk("repeat_first_wins", 32'(done_result), 32'd1);
    handshake();

    // WRITE needs no snoop responses
    issue(32'hDEAD_BEE0, 2'b01);
    chk("wr_done_valid", 32'(done_valid), 32'd1);
    chk("wr_done_result", 32'(done_result), 32'd0);
    chk("wr_done_timeout", 32'(done_timeout), 32'd0);
    chk("wr_done_addr", done_addr, 32'hDEAD_BEE0);
    chk("wr_req_ready", 32'(req_ready), 32'd0);
    handshake();

    // INVALIDATE, only snooper 0 answers -> timeout after 16 collect cycles
    issue(32'h0000_4000, 2'b10);
    snoop(3'b001, 6'b00_00_01);
    for (int c = 2; c <= 15; c++) tick();
    chk("to_not_yet", 32'(done_valid), 32'd0);
    tick();
    chk("to_done_valid", 32'(done_valid), 32'd1);
    chk("to_done_result", 32'(done_result), 32'd1);
    chk("to_done_timeout", 32'(done_timeout), 32'd1);
    chk("to_done_addr", done_addr, 32'h0000_4000);
    handshake();

    // Last snoopers arrive in collect cycle 16: completion beats timeout
    issue(32'h0000_4100, 2'b10);
    snoop(3'b001, 6'b00_00_01);
    for (int c = 2; c <= 15; c++) tick();
    chk("late_not_yet", 32'(done_valid), 32'd0);
    snoop(3'b110, 6'b00_00_00);
    chk("late_done_valid", 32'(done_valid), 32'd1);
    chk("late_done_result", 32'(done_result), 32'd1);
    chk("late_done_timeout", 32'(done_timeout), 32'd0);
    handshake();

    // Reset mid-collect aborts, then a fresh request starts from a clean mask
    issue(32'h0000_5000, 2'b00);
    snoop(3'b001, 6'b00_00_10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_idle", 32'(req_ready), 32'd1);
    chk("abort_no_done", 32'(done_valid), 32'd0);
    // snoop traffic in IDLE is ignored
    snoop(3'b111, 6'b10_10_10);
    chk("idle_snoop_no_done", 32'(done_valid), 32'd0);
    chk("idle_snoop_ready", 32'(req_ready), 32'd1);
    issue(32'h0000_6000, 2'b00);
    snoop(3'b110, 6'b00_01_00);
    chk("clean_mask_wait", 32'(done_valid), 32'd0);
    snoop(3'b001, 6'b00_00_00);
    chk("clean_done_valid", 32'(done_valid), 32'd1);
    chk("clean_done_result", 32'(done_result), 32'd1);
    chk("clean_done_addr", done_addr, 32'h0000_6000);
    chk("clean_done_timeout", 32'(done_timeout), 32'd0);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
